// File: rtl/ariane_reset_sequencer.sv
// Per-tile core reset sequencer: wake-up delay, staggered core release,
// then one-at-a-time servicing of per-core soft-reset requests.
module ariane_reset_sequencer #(
    parameter int NUM_CORES      = 4,
    parameter int WAKE_CYCLES    = 5019,
    parameter int STAGGER_CYCLES = 64,
    parameter int HOLD_CYCLES    = 16,
    parameter int CNT_W          = 16,
    localparam int IDX_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_l,
    input  logic [NUM_CORES-1:0] core_en_i,
    input  logic [NUM_CORES-1:0] soft_rst_req_i,
    output logic [NUM_CORES-1:0] core_rst_no,
    output logic [IDX_W-1:0]     cur_core_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int MAX_WS  = (WAKE_CYCLES > STAGGER_CYCLES) ? WAKE_CYCLES : STAGGER_CYCLES;
    localparam int MAX_CYC = (MAX_WS > HOLD_CYCLES) ? MAX_WS : HOLD_CYCLES;

    generate
        if (NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_num_cores
            $error("ariane_reset_sequencer: NUM_CORES must be in 1..16");
        end
        if (WAKE_CYCLES < 1 || STAGGER_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cycles
            $error("ariane_reset_sequencer: cycle parameters must be >= 1");
        end
        if (CNT_W < 1 || CNT_W > 31 || longint'(MAX_CYC - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
            $error("ariane_reset_sequencer: CNT_W too small for the longest interval");
        end
    endgenerate

    localparam logic [CNT_W-1:0] WAKE_LAST    = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CORES - 1);

    localparam logic [2:0] ST_WAKE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd1;
    localparam logic [2:0] ST_STAGGER = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    logic [2:0]           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [NUM_CORES-1:0] rst_n_reg, rst_n_next;
    logic [NUM_CORES-1:0] pending_reg, pending_next;
    logic [NUM_CORES-1:0] req_accept;
    logic [IDX_W-1:0]     first_pending;
    logic [CNT_W-1:0]     cnt_inc;

    // A request only counts for an enabled core that is currently running.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_req
            assign req_accept[gi] = soft_rst_req_i[gi] & core_en_i[gi] & rst_n_reg[gi];
        end
    endgenerate

    always_comb begin
        first_pending = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                first_pending = IDX_W'(i);
            end
        end
    end

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        rst_n_next   = rst_n_reg;
        pending_next = pending_reg | req_accept;
        case (state_reg)
            ST_WAKE: begin
                if (cnt_reg == WAKE_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_SCAN;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_SCAN: begin
                if (core_en_i[idx_reg]) begin
                    rst_n_next[idx_reg] = 1'b1;
                    cnt_next            = '0;
                    state_next          = ST_STAGGER;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            ST_STAGGER: begin
                if (cnt_reg == STAGGER_LAST) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ST_SCAN;
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_DONE: begin
                // Clearing the served bit wins over a same-cycle request for it.
                if (pending_reg != '0) begin
                    idx_next                   = first_pending;
                    rst_n_next[first_pending]  = 1'b0;
                    pending_next[first_pending] = 1'b0;
                    cnt_next                   = '0;
                    state_next                 = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    rst_n_next[idx_reg] = 1'b1;
                    state_next          = ST_DONE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next   = ST_WAKE;
                cnt_next     = '0;
                idx_next     = '0;
                rst_n_next   = '0;
                pending_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_reg   <= ST_WAKE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            rst_n_reg   <= '0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            rst_n_reg   <= rst_n_next;
            pending_reg <= pending_next;
        end
    end

    assign core_rst_no = rst_n_reg;
    assign cur_core_o  = idx_reg;
    assign busy_o      = (state_reg != ST_DONE);
    assign done_o      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ariane_reset_sequencer.sv
// Bench for ariane_reset_sequencer: schedule/countdown reference model,
// per-cycle comparison, directed timing pins and randomized requests/resets.
module tb_ariane_reset_sequencer;

    localparam int N       = 4;
    localparam int WAKE    = 8;
    localparam int STAGGER = 4;
    localparam int HOLD    = 16;
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;

    logic             clk_i = 1'b0;
    logic             reset_l = 1'b0;
    logic [N-1:0]     core_en_i = '0;
    logic [N-1:0]     soft_rst_req_i = '0;
    logic [N-1:0]     core_rst_no;
    logic [IDX_W-1:0] cur_core_o;
    logic             busy_o;
    logic             done_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    ariane_reset_sequencer #(
        .NUM_CORES(N), .WAKE_CYCLES(WAKE), .STAGGER_CYCLES(STAGGER),
        .HOLD_CYCLES(HOLD), .CNT_W(16)
    ) dut (
        .clk_i(clk_i), .reset_l(reset_l), .core_en_i(core_en_i),
        .soft_rst_req_i(soft_rst_req_i), .core_rst_no(core_rst_no),
        .cur_core_o(cur_core_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: t counts edges since reset release; start-up follows a
    // release schedule, afterwards requests are served lowest-first with a countdown.
    int           t;
    logic [N-1:0] m_rst, m_pend, en_snap;
    int           m_idx, m_phase, m_hold_k, m_hold_left;
    int           tn, tt, scan, ph, hk, hl, idx_l;
    logic [N-1:0] acc, rst_l, pend, en_use;

    always @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            t <= 0; m_rst <= '0; m_pend <= '0; en_snap <= '0;
            m_idx <= 0; m_phase <= 0; m_hold_k <= 0; m_hold_left <= 0;
        end else begin
            tn     = t + 1;
            en_use = (tn == 1) ? core_en_i : en_snap;
            acc    = soft_rst_req_i & core_en_i & m_rst;
            rst_l  = m_rst; pend = m_pend | acc; idx_l = m_idx;
            ph     = m_phase; hk = m_hold_k; hl = m_hold_left;
            if (ph == 0) begin
                tt = WAKE;
                for (int k = 0; k < N; k++) begin
                    scan = tt + 1;
                    if (k > 0 && scan - 1 == tn) idx_l = k;
                    if (en_use[k]) begin
                        if (scan == tn) rst_l[k] = 1'b1;
                        tt = scan + STAGGER;
                    end else begin
                        tt = scan;
                    end
                end
                if (tn == tt) ph = 1;
            end else if (ph == 1) begin
                if (m_pend != '0) begin
                    for (int k = N - 1; k >= 0; k--) if (m_pend[k]) hk = k;
                    rst_l[hk] = 1'b0; pend[hk] = 1'b0; idx_l = hk; hl = HOLD; ph = 2;
                end
            end else begin
                hl = hl - 1;
                if (hl == 0) begin
                    rst_l[hk] = 1'b1; ph = 1;
                end
            end
            t <= tn; en_snap <= en_use; m_rst <= rst_l; m_pend <= pend;
            m_idx <= idx_l; m_phase <= ph; m_hold_k <= hk; m_hold_left <= hl;
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d: got 0x%0h expected 0x%0h", name, t, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cyc core_rst_no", int'(core_rst_no), int'(m_rst));
            check("cyc cur_core_o", int'(cur_core_o), m_idx % (1 << IDX_W));
            check("cyc busy_o", int'(busy_o), int'(m_phase != 1));
            check("cyc done_o", int'(done_o), int'(m_phase == 1));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic goto(int target);
        int n = 0;
        while (t < target && n < 400) begin
            step();
            n++;
        end
        check("goto edge", t, target);
    endtask

    task automatic do_reset(logic [N-1:0] en);
        reset_l = 1'b0;
        soft_rst_req_i = '0;
        core_en_i = en;
        step();
        step();
        reset_l = 1'b1;
        chk_en = 1'b1;
        $display("reset released en=%b", en);
    endtask

    task automatic pulse(int at, logic [N-1:0] mask);
        goto(at - 1);
        soft_rst_req_i = mask;
        $display("req t=%0d mask=%b", at, mask);
        step();
        soft_rst_req_i = '0;
    endtask

    task automatic lit(string name, int at, logic [N-1:0] exp_rst, logic exp_done);
        goto(at);
        check({name, " dut rst"}, int'(core_rst_no), int'(exp_rst));
        check({name, " model rst"}, int'(m_rst), int'(exp_rst));
        check({name, " dut done"}, int'(done_o), int'(exp_done));
        $display("pin %s t=%0d rst=%b done=%b", name, at, core_rst_no, done_o);
    endtask

    initial begin
        step();
        // all enabled, then soft resets from DONE
        do_reset(4'b1111);
        lit("s1 pre", 8, 4'b0000, 1'b0);
        lit("s1 c0", 9, 4'b0001, 1'b0);
        lit("s1 c0 hold", 13, 4'b0001, 1'b0);
        lit("s1 c1", 14, 4'b0011, 1'b0);
        lit("s1 c2", 19, 4'b0111, 1'b0);
        lit("s1 c3", 24, 4'b1111, 1'b0);
        lit("s1 pre done", 27, 4'b1111, 1'b0);
        lit("s1 done", 28, 4'b1111, 1'b1);
        pulse(30, 4'b0110);
        lit("s3 c1 held", 31, 4'b1101, 1'b0);
        lit("s3 c1 end", 46, 4'b1101, 1'b0);
        lit("s3 idle", 47, 4'b1111, 1'b1);
        lit("s3 c2 held", 48, 4'b1011, 1'b0);
        lit("s3 c2 end", 63, 4'b1011, 1'b0);
        lit("s3 done", 64, 4'b1111, 1'b1);
        pulse(66, 4'b0001);
        lit("s6 c0 held", 67, 4'b1110, 1'b0);
        pulse(70, 4'b0001);
        lit("s6 release", 83, 4'b1111, 1'b1);
        lit("s6 no rehold", 86, 4'b1111, 1'b1);

        // partial enable
        do_reset(4'b1010);
        lit("s2 skip0", 9, 4'b0000, 1'b0);
        lit("s2 c1", 10, 4'b0010, 1'b0);
        lit("s2 gap", 15, 4'b0010, 1'b0);
        lit("s2 c3", 16, 4'b1010, 1'b0);
        lit("s2 pre done", 19, 4'b1010, 1'b0);
        lit("s2 done", 20, 4'b1010, 1'b1);
        lit("s2 stay", 40, 4'b1010, 1'b1);

        // request latched during stagger, request for unreleased core dropped
        do_reset(4'b1111);
        pulse(21, 4'b1100);
        lit("s4 done", 28, 4'b1111, 1'b1);
        lit("s4 c2 held", 29, 4'b1011, 1'b0);
        lit("s4 c2 end", 44, 4'b1011, 1'b0);
        lit("s4 release", 45, 4'b1111, 1'b1);
        lit("s4 no c3", 48, 4'b1111, 1'b1);

        // async reset in stagger of core 2
        do_reset(4'b1111);
        goto(20);
        reset_l = 1'b0;
        #1;
        check("s5 async rst", int'(core_rst_no), 0);
        check("s5 async busy", int'(busy_o), 1);
        $display("async reset at t=20 rst=%b", core_rst_no);
        step();
        reset_l = 1'b1;
        lit("s5 c0", 9, 4'b0001, 1'b0);
        lit("s5 c1", 14, 4'b0011, 1'b0);
        lit("s5 c2", 19, 4'b0111, 1'b0);
        lit("s5 c3", 24, 4'b1111, 1'b0);
        lit("s5 done", 28, 4'b1111, 1'b1);

        // randomized runs
        for (int run = 0; run < 8; run++) begin
            do_reset(N'($urandom));
            for (int c = 0; c < 220; c++) begin
                soft_rst_req_i = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
                if (soft_rst_req_i != '0)
                    $display("req t=%0d mask=%b", t + 1, soft_rst_req_i);
                if ($urandom_range(0, 299) == 0) begin
                    reset_l = 1'b0;
                    $display("async reset at t=%0d", t);
                    #1;
                    check("rand async rst", int'(core_rst_no), 0);
                    step();
                    reset_l = 1'b1;
                end
                step();
            end
            soft_rst_req_i = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ariane_reset_sequencer.md
Name: ariane_reset_sequencer

Overview:
Per-tile reset/wake-up controller for a cluster of Ariane cores. After global reset it waits a fixed wake-up interval, then releases core resets one at a time with a programmable stagger, which limits inrush current and L15 request bursts. Once all cores are released it services per-core soft-reset requests, one core at a time. Each core_rst_no bit drives that core wrapper's reset_l input.

Parameters:
NUM_CORES, 4, number of cores sequenced (1..16)
WAKE_CYCLES, 5019, cycles spent in WAKE after reset_l deasserts (>=1)
STAGGER_CYCLES, 64, cycles between successive core releases (>=1)
HOLD_CYCLES, 16, cycles a soft-reset core is held in reset (>=1)
CNT_W, 16, counter width; must hold max(WAKE_CYCLES, STAGGER_CYCLES, HOLD_CYCLES)-1

Ports:
clk_i  input  1  clock
reset_l  input  1  reset, asynchronous, active-low
core_en_i  input  NUM_CORES  per-core enable, quasi-static; a disabled core is never released
soft_rst_req_i  input  NUM_CORES  per-core single-cycle soft-reset request pulse
core_rst_no  output  NUM_CORES  per-core reset, active-low
cur_core_o  output  max(1,$clog2(NUM_CORES))  index currently scanned or held
busy_o  output  1  high in every state except DONE
done_o  output  1  high only in DONE

Behaviour:
- Reset (reset_l low, async):
  - state=WAKE, cnt=0, idx=0, pending=0.
  - core_rst_no=all 0, cur_core_o=0, busy_o=1, done_o=0.
- WAKE:
  - cnt increments each cycle.
  - At cnt==WAKE_CYCLES-1: cnt<=0, go to SCAN.
- SCAN (one cycle per index):
  - If core_en_i[idx]: core_rst_no[idx]<=1, cnt<=0, go to STAGGER.
  - Else if idx==NUM_CORES-1: go to DONE.
  - Else: idx++ and stay in SCAN.
- STAGGER:
  - cnt increments each cycle.
  - At cnt==STAGGER_CYCLES-1: if idx==NUM_CORES-1 go to DONE, else idx++ and go to SCAN.
- Resulting timing: successive enabled cores are released STAGGER_CYCLES+1 edges apart; each disabled core in between adds 1 edge.
- pending register (every state):
  - Sets bit k on soft_rst_req_i[k] && core_en_i[k] && core_rst_no[k]==1.
  - Requests for cores still in reset or disabled are dropped.
- DONE:
  - If pending!=0: k = lowest set bit; idx<=k; core_rst_no[k]<=0; pending[k]<=0; cnt<=0; go to HOLD.
- HOLD:
  - cnt increments each cycle.
  - At cnt==HOLD_CYCLES-1: core_rst_no[idx]<=1, go to DONE.
  - A new request for the held core is dropped, because its core_rst_no is 0.
  - Requests for other cores stay latched in pending.
  - One idle DONE cycle separates back-to-back holds.
- Request rules:
  - Simultaneous requests: the lowest index is served first; the others wait in pending.
  - A request in the same cycle that pending[k] is cleared for DONE->HOLD is dropped.
- Output mapping:
  - cur_core_o = idx.
  - busy_o = (state!=DONE).
  - done_o = (state==DONE).
  - All outputs are registered; no combinational path from inputs to outputs.
- core_en_i deasserting after release has no effect until the next global reset.
- reset_l asserted mid-sequence (any state): all cores return to reset immediately (async), pending is cleared, and the sequence restarts from WAKE.
- Counter compares use CNT_W-bit unsigned arithmetic; the counter never wraps. A parameter check fails elaboration if CNT_W is too small.

Test Plan:
1. NUM_CORES=4, WAKE=8, STAGGER=4, all enabled, release reset_l at edge 0 -> core_rst_no[0] rises at edge 9, [1] at 14, [2] at 19, [3] at 24; done_o rises at edge 28.
2. Same config, core_en_i=4'b1010 -> [1] rises at edge 10, [3] at 16; [0] and [2] stay 0 forever; done_o rises at edge 20.
3. In DONE, HOLD=16, pulse soft_rst_req_i=4'b0110 in one cycle -> core 1 low for 16 cycles, one idle DONE cycle, then core 2 low for 16 cycles; busy_o high throughout both holds.
4. Pulse soft_rst_req_i[2] during STAGGER after core 2 was released -> latched, and core 2 held for HOLD_CYCLES immediately after DONE is entered. Pulse for core 3 (still in reset) -> ignored.
5. Assert reset_l low for 1 cycle during STAGGER of core 2 -> all core_rst_no=0 asynchronously, pending=0, full timing of scenario 1 repeats.
6. Pulse soft_rst_req_i[0] while core 0 is in HOLD -> dropped; core 0 held exactly HOLD_CYCLES once.
